// File: rtl/ladybird_spi_flash_reader.sv
// ladybird_spi_flash_reader
//
// Read-only bus responder that fetches one 32-bit word per request from a
// serial NOR flash using the single-bit SPI READ command (0x03), SPI mode 0.
// Each read is a 64-bit frame on the wire: command byte, 24-bit word-aligned
// address, then 32 data bits clocked in from MISO.
// FLASH_ADDR_W is expected to be 24, matching the 3-byte address of READ.
//
// Ports:
//   clk         system clock
//   nrst        asynchronous active-low reset
//   req_valid   request present
//   req_ready   responder can accept a request (IDLE and CS gap expired)
//   req_we      write request; answered with resp_error, no flash activity
//   req_addr    flash byte address, bits 1:0 ignored
//   resp_valid  single-cycle response strobe, no backpressure
//   resp_data   read data, held until the next response
//   resp_error  set with resp_valid when the request was a write
//   spi_sck     flash clock (idle low)
//   spi_cs_n    flash chip select, active-low
//   spi_mosi    serial data to the flash (qspi_dq[0])
//   spi_miso    serial data from the flash (qspi_dq[1])

module ladybird_spi_flash_reader #(
   parameter int CLK_DIV        = 2,
   parameter int CS_HIGH_CYCLES = 4,
   parameter int FLASH_ADDR_W   = 24
) (
   input  logic                    clk,
   input  logic                    nrst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [FLASH_ADDR_W-1:0] req_addr,
   output logic                    resp_valid,
   output logic [31:0]             resp_data,
   output logic                    resp_error,
   output logic                    spi_sck,
   output logic                    spi_cs_n,
   output logic                    spi_mosi,
   input  logic                    spi_miso
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GAP_W = $clog2(CS_HIGH_CYCLES + 1);

   localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};
   localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CS_HIGH_CYCLES);
   localparam logic [7:0]       CMD_READ = 8'h03;
   localparam logic [5:0]       BIT_LAST = 6'd63;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   // The flash returns the lowest-addressed byte first; the bus word is little-endian.
   function automatic logic [31:0] flash_bytes_to_word(input logic [31:0] rx);
      return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
   endfunction

   state_t             state_q,      state_d;
   logic [GAP_W-1:0]   gap_q,        gap_d;
   logic [DIV_W-1:0]   div_q,        div_d;
   logic [5:0]         bit_q,        bit_d;
   logic [63:0]        frame_q,      frame_d;
   logic [31:0]        rx_q,         rx_d;
   logic               sck_q,        sck_d;
   logic               cs_n_q,       cs_n_d;
   logic               req_ready_q,  req_ready_d;
   logic               resp_valid_q, resp_valid_d;
   logic               resp_error_q, resp_error_d;
   logic [31:0]        resp_data_q,  resp_data_d;

   // Word alignment drops the two low address bits.
   logic unused_addr_s;
   assign unused_addr_s = ^req_addr[1:0];

   // Next-state logic for the transfer sequencer and all registered outputs.
   always_comb begin
      state_d      = state_q;
      gap_d        = gap_q;
      div_d        = div_q;
      bit_d        = bit_q;
      frame_d      = frame_q;
      rx_d         = rx_q;
      sck_d        = sck_q;
      cs_n_d       = cs_n_q;
      req_ready_d  = 1'b0;
      resp_valid_d = 1'b0;
      resp_error_d = 1'b0;
      resp_data_d  = resp_data_q;

      case (state_q)
         ST_IDLE: begin
            // The CS-high gap keeps counting down here after reset.
            if (gap_q != GAP_ZERO) begin
               gap_d = gap_q - GAP_ONE;
            end else begin
               gap_d = GAP_ZERO;
            end
            if (req_valid && req_ready_q) begin
               if (req_we) begin
                  resp_valid_d = 1'b1;
                  resp_error_d = 1'b1;
                  resp_data_d  = 32'h0000_0000;
               end else begin
                  frame_d = {CMD_READ, req_addr[23:2], 2'b00, 32'h0000_0000};
                  bit_d   = 6'd0;
                  div_d   = DIV_ZERO;
                  sck_d   = 1'b0;
                  cs_n_d  = 1'b0;
                  state_d = ST_SHIFT;
               end
            end else begin
               req_ready_d = (gap_d == GAP_ZERO);
            end
         end

         ST_SHIFT: begin
            if (div_q == DIV_LAST) begin
               div_d = DIV_ZERO;
               if (!sck_q) begin
                  // Rising SCK: data bits sit in the second half of the frame.
                  sck_d = 1'b1;
                  if (bit_q[5]) begin
                     rx_d = {rx_q[30:0], spi_miso};
                  end else begin
                     rx_d = rx_q;
                  end
               end else begin
                  // Falling SCK: either advance to the next bit or finish.
                  sck_d = 1'b0;
                  if (bit_q == BIT_LAST) begin
                     state_d      = ST_DONE;
                     cs_n_d       = 1'b1;
                     frame_d      = 64'h0;
                     gap_d        = GAP_LOAD;
                     resp_valid_d = 1'b1;
                     resp_error_d = 1'b0;
                     resp_data_d  = flash_bytes_to_word(rx_q);
                  end else begin
                     bit_d   = bit_q + 6'd1;
                     frame_d = {frame_q[62:0], 1'b0};
                  end
               end
            end else begin
               div_d = div_q + DIV_ONE;
            end
         end

         ST_DONE, ST_GAP: begin
            // The DONE cycle is the first of the CS-high gap.
            if (gap_q > GAP_ONE) begin
               gap_d   = gap_q - GAP_ONE;
               state_d = ST_GAP;
            end else begin
               gap_d       = GAP_ZERO;
               state_d     = ST_IDLE;
               req_ready_d = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cs_n_d  = 1'b1;
            sck_d   = 1'b0;
            frame_d = 64'h0;
            gap_d   = GAP_LOAD;
         end
      endcase
   end

   // State and output registers; reset aborts any transfer and raises CS at once.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q      <= ST_IDLE;
         gap_q        <= GAP_LOAD;
         div_q        <= DIV_ZERO;
         bit_q        <= 6'd0;
         frame_q      <= 64'h0;
         rx_q         <= 32'h0000_0000;
         sck_q        <= 1'b0;
         cs_n_q       <= 1'b1;
         req_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_error_q <= 1'b0;
         resp_data_q  <= 32'h0000_0000;
      end else begin
         state_q      <= state_d;
         gap_q        <= gap_d;
         div_q        <= div_d;
         bit_q        <= bit_d;
         frame_q      <= frame_d;
         rx_q         <= rx_d;
         sck_q        <= sck_d;
         cs_n_q       <= cs_n_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_error_q <= resp_error_d;
         resp_data_q  <= resp_data_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_error = resp_error_q;
   assign resp_data  = resp_data_q;
   assign spi_sck    = sck_q;
   assign spi_cs_n   = cs_n_q;
   // The frame register MSB is the bit currently on the wire.
   assign spi_mosi   = frame_q[63];

endmodule

// File: tb/tb_ladybird_spi_flash_reader.sv
// Testbench for ladybird_spi_flash_reader with a behavioural SPI READ flash model.

module tb_ladybird_spi_flash_reader;

   localparam int CLK_DIV = 2;
   localparam int CS_HIGH = 4;

   logic        clk       = 1'b0;
   logic        nrst      = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we    = 1'b0;
   logic [23:0] req_addr  = 24'h0;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_error;
   logic        spi_sck;
   logic        spi_cs_n;
   logic        spi_mosi;
   logic        spi_miso;

   int checks = 0;
   int errors = 0;

   // Flash model / bus monitors
   int          cyc           = 0;
   int          rise_total    = 0;
   int          cs_fall_total = 0;
   int          bad_period    = 0;
   int          high_total    = 0;
   int          last_rise_cyc = 0;
   logic [6:0]  rise_cnt      = 7'd0;
   logic [63:0] mosi_sr       = 64'h0;
   logic [31:0] flash_word    = 32'h0;
   logic [4:0]  miso_idx;

   ladybird_spi_flash_reader #(
      .CLK_DIV(CLK_DIV),
      .CS_HIGH_CYCLES(CS_HIGH),
      .FLASH_ADDR_W(24)
   ) dut (
      .clk(clk),
      .nrst(nrst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_we(req_we),
      .req_addr(req_addr),
      .resp_valid(resp_valid),
      .resp_data(resp_data),
      .resp_error(resp_error),
      .spi_sck(spi_sck),
      .spi_cs_n(spi_cs_n),
      .spi_mosi(spi_mosi),
      .spi_miso(spi_miso)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   always @(negedge clk) if (spi_sck === 1'b1) high_total = high_total + 1;

   // After 32 rising edges the flash streams flash_word out MSB first.
   assign miso_idx = ~rise_cnt[4:0];
   assign spi_miso = (rise_cnt[6:5] == 2'b01) ? flash_word[miso_idx] : 1'b0;

   always @(posedge spi_sck or negedge spi_cs_n) begin
      if (spi_sck) begin
         if (rise_cnt != 7'd0 && (cyc - last_rise_cyc) != 2 * CLK_DIV) bad_period = bad_period + 1;
         last_rise_cyc = cyc;
         rise_cnt      = rise_cnt + 7'd1;
         rise_total    = rise_total + 1;
         mosi_sr       = {mosi_sr[62:0], spi_mosi};
      end else begin
         rise_cnt      = 7'd0;
         mosi_sr       = 64'h0;
         cs_fall_total = cs_fall_total + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (req_ready !== 1'b1 && n < 600) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_ready: req_ready=%b expected 1", name, req_ready);
      end
   endtask

   task automatic do_read(input string name, input logic [23:0] addr, input logic [31:0] word,
                          input logic [31:0] exp_cmd, input logic [31:0] exp_data);
      int lat, rise0, high0, bad0;
      logic prev_cs;
      flash_word = word;
      req_addr   = addr;
      req_we     = 1'b0;
      req_valid  = 1'b1;
      wait_ready(name);
      rise0 = rise_total;
      high0 = high_total;
      bad0  = bad_period;
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if (spi_cs_n !== 1'b0 || spi_sck !== 1'b0 || spi_mosi !== exp_cmd[31]) begin
         errors++;
         $display("FAIL %s_start: cs_n=%b sck=%b mosi=%b expected 0 0 %b", name, spi_cs_n, spi_sck, spi_mosi, exp_cmd[31]);
      end
      lat = 1;
      prev_cs = spi_cs_n;
      while (resp_valid !== 1'b1 && lat < 400) begin
         prev_cs = spi_cs_n;
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat != 257) begin
         errors++;
         $display("FAIL %s_latency: got %0d expected 257", name, lat);
      end
      checks++;
      if (prev_cs !== 1'b0 || spi_cs_n !== 1'b1) begin
         errors++;
         $display("FAIL %s_cs_rise: cs_n before=%b at resp=%b expected 0 then 1", name, prev_cs, spi_cs_n);
      end
      checks++;
      if (resp_data !== exp_data || resp_error !== 1'b0) begin
         errors++;
         $display("FAIL %s_data: data=%h err=%b expected %h 0", name, resp_data, resp_error, exp_data);
      end
      checks++;
      if (mosi_sr !== {exp_cmd, 32'h0}) begin
         errors++;
         $display("FAIL %s_mosi: got %h expected %h", name, mosi_sr, {exp_cmd, 32'h0});
      end
      checks++;
      if (rise_total - rise0 != 64 || high_total - high0 != 128 || bad_period != bad0) begin
         errors++;
         $display("FAIL %s_sck: pulses=%0d high=%0d bad_periods=%0d expected 64 128 0",
                  name, rise_total - rise0, high_total - high0, bad_period - bad0);
      end
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b0 || spi_sck !== 1'b0) begin
         errors++;
         $display("FAIL %s_after: resp_valid=%b req_ready=%b sck=%b expected 0 0 0", name, resp_valid, req_ready, spi_sck);
      end
   endtask

   task automatic test_reset();
      nrst      = 1'b0;
      req_valid = 1'b1;
      req_addr  = 24'h000104;
      repeat (3) @(negedge clk);
      checks++;
      if (spi_cs_n !== 1'b1 || spi_sck !== 1'b0 || spi_mosi !== 1'b0) begin
         errors++;
         $display("FAIL reset_pins: cs_n=%b sck=%b mosi=%b expected 1 0 0", spi_cs_n, spi_sck, spi_mosi);
      end
      checks++;
      if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_data !== 32'h0 || resp_error !== 1'b0) begin
         errors++;
         $display("FAIL reset_bus: ready=%b valid=%b data=%h err=%b expected 0 0 0 0",
                  req_ready, resp_valid, resp_data, resp_error);
      end
      req_valid = 1'b0;
      nrst      = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_gap_early: req_ready=%b expected 0", req_ready);
      end
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_gap_done: req_ready=%b expected 1", req_ready);
      end
   endtask

   task automatic test_read();
      do_read("read_aligned", 24'h000104, 32'hEFBEADDE, 32'h03000104, 32'hDEADBEEF);
   endtask

   task automatic test_misaligned();
      do_read("read_misaligned", 24'h000107, 32'hEFBEADDE, 32'h03000104, 32'hDEADBEEF);
   endtask

   task automatic test_write();
      int fall0, rise0;
      req_valid = 1'b0;
      wait_ready("write_pre");
      req_addr  = 24'h000010;
      req_we    = 1'b1;
      req_valid = 1'b1;
      fall0 = cs_fall_total;
      rise0 = rise_total;
      @(negedge clk);
      req_valid = 1'b0;
      req_we    = 1'b0;
      checks++;
      if (resp_valid !== 1'b1 || resp_error !== 1'b1 || resp_data !== 32'h0 || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL write_resp: valid=%b err=%b data=%h ready=%b expected 1 1 0 0",
                  resp_valid, resp_error, resp_data, req_ready);
      end
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0 || resp_error !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL write_after: valid=%b err=%b ready=%b expected 0 0 1", resp_valid, resp_error, req_ready);
      end
      repeat (10) @(negedge clk);
      checks++;
      if (cs_fall_total != fall0 || rise_total != rise0 || spi_cs_n !== 1'b1 || spi_sck !== 1'b0) begin
         errors++;
         $display("FAIL write_no_flash: cs_falls=%0d sck_rises=%0d cs_n=%b sck=%b expected 0 0 1 0",
                  cs_fall_total - fall0, rise_total - rise0, spi_cs_n, spi_sck);
      end
   endtask

   task automatic test_back_to_back();
      int c, d, acc, n_resp, ready_bad;
      logic [31:0] first_data, second_data;
      n_resp = 0;
      ready_bad = 0;
      first_data = 32'h0;
      second_data = 32'h0;
      flash_word = 32'hEFBEADDE;
      req_addr   = 24'h000104;
      req_we     = 1'b0;
      req_valid  = 1'b1;
      wait_ready("b2b_first");
      @(negedge clk);
      req_addr = 24'h000208;
      c = 1;
      while (resp_valid !== 1'b1 && c < 400) begin
         if (req_ready !== 1'b0) ready_bad++;
         @(negedge clk);
         c++;
      end
      if (req_ready !== 1'b0) ready_bad++;
      if (resp_valid === 1'b1) n_resp++;
      first_data = resp_data;
      d = c;
      flash_word = 32'h44332211;
      while (req_ready !== 1'b1 && c < d + 50) begin
         @(negedge clk);
         c++;
         if (resp_valid === 1'b1) n_resp++;
      end
      acc = c;
      @(negedge clk);
      c++;
      req_valid = 1'b0;
      while (resp_valid !== 1'b1 && c < acc + 400) begin
         @(negedge clk);
         c++;
      end
      if (resp_valid === 1'b1) n_resp++;
      second_data = resp_data;
      checks++;
      if (c - acc != 257) begin
         errors++;
         $display("FAIL b2b_latency: got %0d expected 257", c - acc);
      end
      checks++;
      if (mosi_sr !== {32'h03000208, 32'h0}) begin
         errors++;
         $display("FAIL b2b_mosi: got %h expected %h", mosi_sr, {32'h03000208, 32'h0});
      end
      repeat (20) begin
         @(negedge clk);
         if (resp_valid === 1'b1) n_resp++;
      end
      checks++;
      if (ready_bad != 0) begin
         errors++;
         $display("FAIL b2b_ready_busy: ready high %0d cycles expected 0", ready_bad);
      end
      checks++;
      if (acc - d < 4) begin
         errors++;
         $display("FAIL b2b_gap: accept at DONE+%0d expected at least DONE+4", acc - d);
      end
      checks++;
      if (first_data !== 32'hDEADBEEF || second_data !== 32'h11223344) begin
         errors++;
         $display("FAIL b2b_order: got %h %h expected deadbeef 11223344", first_data, second_data);
      end
      checks++;
      if (n_resp != 2) begin
         errors++;
         $display("FAIL b2b_count: got %0d responses expected 2", n_resp);
      end
   endtask

   task automatic test_reset_mid();
      int n, spurious;
      spurious = 0;
      flash_word = 32'hEFBEADDE;
      req_addr   = 24'h000300;
      req_we     = 1'b0;
      req_valid  = 1'b1;
      wait_ready("abort_start");
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (rise_cnt != 7'd41 && n < 400) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (rise_cnt != 7'd41 || spi_cs_n !== 1'b0) begin
         errors++;
         $display("FAIL abort_reach_bit40: rises=%0d cs_n=%b expected 41 0", rise_cnt, spi_cs_n);
      end
      nrst = 1'b0;
      #1;
      checks++;
      if (spi_cs_n !== 1'b1 || spi_sck !== 1'b0 || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL abort_immediate: cs_n=%b sck=%b ready=%b expected 1 0 0", spi_cs_n, spi_sck, req_ready);
      end
      repeat (3) begin
         @(negedge clk);
         if (resp_valid !== 1'b0) spurious++;
      end
      nrst = 1'b1;
      repeat (300) begin
         @(negedge clk);
         if (resp_valid !== 1'b0) spurious++;
      end
      checks++;
      if (spurious != 0) begin
         errors++;
         $display("FAIL abort_no_resp: saw %0d resp_valid cycles expected 0", spurious);
      end
      do_read("read_after_abort", 24'h000200, 32'h78563412, 32'h03000200, 32'h12345678);
   endtask

   initial begin
      test_reset();
      test_read();
      test_misaligned();
      test_write();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
